// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared key/value widths for the priority queue blocks
package pq_pkg;
    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;
endpackage

// File: rtl/sr_pq.sv
// rtl/sr_pq.sv - shift-register priority queue, ascending key, FIFO among equal keys
module sr_pq #(
    parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
    parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
    parameter int DEPTH     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enq,
    input  logic                           deq,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
    output logic                           ovalid,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           ovf,
    output logic                           udf
);
    localparam int CW = $clog2(DEPTH+1);

    logic [KEY_WIDTH-1:0] key_q [DEPTH];
    logic [KEY_WIDTH-1:0] key_d [DEPTH];
    logic [VAL_WIDTH-1:0] val_q [DEPTH];
    logic [VAL_WIDTH-1:0] val_d [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d, udf_q, udf_d;

    logic [KEY_WIDTH-1:0] new_key;
    logic [VAL_WIDTH-1:0] new_val;
    logic                 is_empty, is_full;
    // gt[i]: cell i must sit after the new item; gt[DEPTH] is the virtual tail.
    logic [DEPTH:0]       gt;
    logic [KEY_WIDTH-1:0] nxt_key [DEPTH+1];
    logic [VAL_WIDTH-1:0] nxt_val [DEPTH+1];
    logic [DEPTH:0]       nxt_valid;

    assign new_key  = kvi[KEY_WIDTH+VAL_WIDTH-1:VAL_WIDTH];
    assign new_val  = kvi[VAL_WIDTH-1:0];
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    always_comb begin
        gt        = '0;
        nxt_valid = '0;
        for (int i = 0; i <= DEPTH; i++) begin
            nxt_key[i] = '0;
            nxt_val[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            gt[i] = !valid_q[i] || (key_q[i] > new_key);
        end
        gt[DEPTH] = 1'b1;
        // Left neighbour view, padded with an empty cell past the tail.
        for (int i = 0; i < DEPTH - 1; i++) begin
            nxt_key[i]   = key_q[i+1];
            nxt_val[i]   = val_q[i+1];
            nxt_valid[i] = valid_q[i+1];
        end
    end

    always_comb begin
        key_d   = key_q;
        val_d   = val_q;
        valid_d = valid_q;
        count_d = count_q;
        ovf_d   = enq && !deq && is_full;
        udf_d   = deq && is_empty;

        if (deq && !is_empty) begin
            if (enq) begin
                // Replace head: cells before the slot shift left, slot takes kvi, rest hold.
                for (int i = 0; i < DEPTH; i++) begin
                    if (!gt[i+1]) begin
                        key_d[i]   = nxt_key[i];
                        val_d[i]   = nxt_val[i];
                        valid_d[i] = nxt_valid[i];
                    end else if ((i == 0) || !gt[i]) begin
                        key_d[i]   = new_key;
                        val_d[i]   = new_val;
                        valid_d[i] = 1'b1;
                    end
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    key_d[i]   = nxt_key[i];
                    val_d[i]   = nxt_val[i];
                    valid_d[i] = nxt_valid[i];
                end
                count_d = count_q - 1'b1;
            end
        end else if (enq && !is_full) begin
            if (gt[0]) begin
                key_d[0]   = new_key;
                val_d[0]   = new_val;
                valid_d[0] = 1'b1;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (gt[i-1]) begin
                    key_d[i]   = key_q[i-1];
                    val_d[i]   = val_q[i-1];
                    valid_d[i] = valid_q[i-1];
                end else if (gt[i]) begin
                    key_d[i]   = new_key;
                    val_d[i]   = new_val;
                    valid_d[i] = 1'b1;
                end
            end
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            key_q   <= key_d;
            val_q   <= val_d;
            valid_q <= valid_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Invalid cells always hold zero, so the head reads 0 when empty.
    assign kvo    = {key_q[0], val_q[0]};
    assign count  = count_q;
    assign empty  = is_empty;
    assign full   = is_full;
    assign ovalid = !is_empty;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

    a_count_matches_valid: assert property (@(posedge clk) disable iff (!rst_n)
        count_q == CW'($countones(valid_q)));

endmodule

// File: tb/tb_sr_pq.sv
// tb/tb_sr_pq.sv - directed plus random check of sr_pq against a sorted-queue model
module tb_sr_pq;
    localparam int KW = 8;
    localparam int VW = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D+1);

    typedef struct packed {
        logic [KW-1:0] k;
        logic [VW-1:0] v;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enq = 1'b0;
    logic            deq = 1'b0;
    logic [KW+VW-1:0] kvi = '0;
    logic [KW+VW-1:0] kvo;
    logic            ovalid, empty, full, ovf, udf;
    logic [CW-1:0]   count;

    int n_assert = 0;
    int n_fail   = 0;

    entry_t model_q[$];
    logic   exp_ovf = 1'b0;
    logic   exp_udf = 1'b0;

    sr_pq #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kvi(kvi),
        .kvo(kvo), .ovalid(ovalid), .empty(empty), .full(full),
        .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [KW+VW-1:0] e_kvo;
        e_kvo = (model_q.size() > 0) ? {model_q[0].k, model_q[0].v} : '0;
        chk({tag, ".kvo"},    32'(kvo),    32'(e_kvo));
        chk({tag, ".count"},  32'(count),  32'(model_q.size()));
        chk({tag, ".empty"},  32'(empty),  32'(model_q.size() == 0));
        chk({tag, ".full"},   32'(full),   32'(model_q.size() == D));
        chk({tag, ".ovalid"}, 32'(ovalid), 32'(model_q.size() != 0));
        chk({tag, ".ovf"},    32'(ovf),    32'(exp_ovf));
        chk({tag, ".udf"},    32'(udf),    32'(exp_udf));
    endtask

    function automatic void model_insert(input entry_t e);
        int p;
        p = model_q.size();
        for (int i = 0; i < model_q.size(); i++) begin
            if (model_q[i].k > e.k) begin
                p = i;
                break;
            end
        end
        model_q.insert(p, e);
    endfunction

    task automatic op(input logic e, input logic d, input logic [KW-1:0] k,
                      input logic [VW-1:0] v, input string tag);
        entry_t it;
        it      = '{k: k, v: v};
        enq     = e;
        deq     = d;
        kvi     = e ? {k, v} : 16'($urandom);
        exp_ovf = e && !d && (model_q.size() == D);
        exp_udf = d && (model_q.size() == 0);
        if (d && model_q.size() > 0) void'(model_q.pop_front());
        if (e && !exp_ovf) model_insert(it);
        @(posedge clk);
        #1;
        enq = 1'b0;
        deq = 1'b0;
        chk_all(tag);
    endtask

    task automatic idle(input string tag);
        op(1'b0, 1'b0, '0, '0, tag);
    endtask

    initial begin
        #12;
        chk_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        op(1, 0, 8, 14, "enq8");
        chk("head_before_deq", 32'(kvo), 32'h080e);
        op(1, 1, 2, 12, "rep2");
        chk("rep2_kvo", 32'(kvo), 32'h020c);
        op(1, 0, 9, 10, "enq9a");
        op(1, 0, 9, 11, "enq9b");
        op(1, 0, 9, 12, "enq9c");
        chk("four_count", 32'(count), 32'd4);
        op(1, 1, 1, 11, "rep1_full");
        chk("rep1_kvo", 32'(kvo), 32'h010b);
        chk("rep1_fifo_tail", 32'(model_q[3]), 32'h090c);
        op(0, 1, 0, 0, "deq1");
        chk("fifo_9a", 32'(kvo), 32'h090a);
        op(0, 1, 0, 0, "deq2");
        chk("fifo_9b", 32'(kvo), 32'h090b);
        op(0, 1, 0, 0, "deq3");
        chk("fifo_9c", 32'(kvo), 32'h090c);
        op(0, 1, 0, 0, "deq4");
        chk("drained_empty", 32'(empty), 32'd1);

        op(1, 0, 5, 1, "fill5");
        op(1, 0, 3, 2, "fill3");
        op(1, 0, 7, 3, "fill7");
        op(1, 0, 1, 4, "fill1");
        chk("fill_full", 32'(full), 32'd1);
        op(1, 0, 0, 9, "ovf");
        chk("ovf_pulse", 32'(ovf), 32'd1);
        idle("ovf_clear");
        op(1, 1, 0, 8'h5a, "rep_full");
        chk("rep_full_head", 32'(kvo), 32'h005a);

        repeat (4) op(0, 1, 0, 0, "drain");
        op(0, 1, 0, 0, "udf");
        chk("udf_pulse", 32'(udf), 32'd1);
        op(1, 1, 4, 4, "udf_enq");
        chk("udf_enq_kvo", 32'(kvo), 32'h0404);

        op(1, 0, 2, 2, "pre_rst_a");
        op(1, 0, 9, 9, "pre_rst_b");
        enq   = 1'b1;
        kvi   = 16'h0101;
        #1;
        rst_n = 1'b0;
        #2;
        model_q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        chk_all("async_rst");
        enq = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_all("post_rst");
        op(1, 0, 6, 6, "after_rst");
        chk("after_rst_kvo", 32'(kvo), 32'h0606);

        for (int n = 0; n < 400; n++) begin
            op(1'($urandom), 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
